// File: rtl/sync_fifo_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo_buffer : single-clock FIFO with occupancy count, programmable
//                    almost-full/almost-empty levels, flush and sticky errors
// Revision 1.0
// ----------------------------------------------------------------------------
module sync_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_MARGIN  = 4,
  parameter int AE_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_half     = (ADDR_WIDTH + 1)'(DEPTH / 2);
  localparam logic [ADDR_WIDTH:0] c_af_level = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] c_ae_level = (ADDR_WIDTH + 1)'(AE_MARGIN);
  localparam logic [ADDR_WIDTH:0] c_one      = (ADDR_WIDTH + 1)'(1);

  generate
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
      $error("sync_fifo_buffer: ADDR_WIDTH must be >= 1");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_af_margin
      $error("sync_fifo_buffer: AF_MARGIN must be in 1..DEPTH-1");
    end
    if (AE_MARGIN < 1 || AE_MARGIN > DEPTH - 1) begin : g_bad_ae_margin
      $error("sync_fifo_buffer: AE_MARGIN must be in 1..DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_active;
  logic w_wr_acc;
  logic w_rd_acc;

  // Acceptance is judged on the pre-edge count only: no read bypass on empty,
  // no write-through-read on full.
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_active = ~rst & ~clear;
  assign w_wr_acc = w_active & wr_en & ~w_full;
  assign w_rd_acc = w_active & rd_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem[r_wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_data_out <= mem[r_rptr];
        r_rptr     <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign data_out     = r_data_out;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign half         = (r_count == c_half);
  assign almost_full  = (r_count >= c_af_level);
  assign almost_empty = (r_count <= c_ae_level);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sync_fifo_buffer : randomized and directed bench with a queue-based model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_sync_fifo_buffer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full, empty, half, almost_full, almost_empty, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a queue plus the observable registered state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_rv   = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;

  sync_fifo_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(4), .AE_MARGIN(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .half(half), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    int   sz;
    logic wok, rok;
    sz  = m_q.size();
    wok = w && (sz < DEPTH);
    rok = r && (sz > 0);
    wr_en = w; data_in = d; rd_en = r; clear = c;
    @(posedge clk);
    if (c) begin
      m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
    end else begin
      if (rok) m_dout = m_q.pop_front();
      m_rv = rok;
      if (wok) m_q.push_back(d);
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_unf = 1'b1;
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset(input logic w);
    rst = 1'b1; wr_en = w; data_in = 8'h5A;
    @(posedge clk);
    m_q.delete(); m_dout = '0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    rst = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got, exp;
    do_reset(1'b0);
    got = {rd_valid, full, empty, half, almost_full, almost_empty, overflow, underflow, 2'b00};
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_flags got=%b exp=%b", got, exp); end
    n_checks++;
    if (count !== 5'd0 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_count_data got count=%0d data=%h exp 0/00", count, data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (count !== 5'(i + 1) || full !== (i == 15) || half !== (i == 7) ||
          almost_full !== (i >= 11)) begin
        n_fail++;
        $display("FAIL fill_%0d got count=%0d full=%b half=%b af=%b exp count=%0d full=%b half=%b af=%b",
                 i, count, full, half, almost_full, i + 1, i == 15, i == 7, i >= 11);
      end
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_fail++; $display("FAIL overflow got ovf=%b count=%0d full=%b exp 1/16/1", overflow, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || data_out !== 8'(i)) begin
        n_fail++; $display("FAIL drain_%0d got rv=%b data=%h exp 1/%h", i, rd_valid, data_out, 8'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || data_out !== 8'h0F) begin
      n_fail++; $display("FAIL underflow got unf=%b rv=%b data=%h exp 1/0/0f", underflow, rd_valid, data_out);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || data_out !== 8'(8'hA0 + i)) begin
        n_fail++; $display("FAIL wrap_rd_%0d got rv=%b data=%h exp 1/%h", i, rd_valid, data_out, 8'(8'hA0 + i));
      end
    end
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end got count=%0d empty=%b unf=%b exp 0/1/0", count, empty, underflow);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      n_checks++;
      if (count !== 5'd5 || rd_valid !== 1'b1 || data_out !== 8'(8'h30 + i)) begin
        n_fail++; $display("FAIL simul_%0d got count=%0d rv=%b data=%h exp 5/1/%h",
                           i, count, rd_valid, data_out, 8'(8'h30 + i));
      end
    end
    for (int i = 0; i < 11; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    n_checks++;
    if (count !== 5'd15 || overflow !== 1'b1 || rd_valid !== 1'b1 || data_out !== 8'h33) begin
      n_fail++; $display("FAIL simul_full got count=%0d ovf=%b rv=%b data=%h exp 15/1/1/33",
                         count, overflow, rd_valid, data_out);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul_empty got count=%0d unf=%b rv=%b ovf=%b exp 1/1/0/0",
                         count, underflow, rd_valid, overflow);
    end
  endtask

  task automatic test_clear_rst();
    logic [DW-1:0] held;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    held = m_dout;
    drive(1'b1, 8'hD1, 1'b1, 1'b1);
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b0 ||
        rd_valid !== 1'b0 || data_out !== held) begin
      n_fail++; $display("FAIL clear_mid got count=%0d empty=%b unf=%b ovf=%b rv=%b data=%h exp 0/1/0/0/0/%h",
                         count, empty, underflow, overflow, rd_valid, data_out, held);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++; $display("FAIL clear_nowrite got rv=%b count=%0d exp 0/0", rd_valid, count);
    end
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'hE1 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset(1'b1);
    n_checks++;
    if (count !== 5'd0 || data_out !== 8'h00 || empty !== 1'b1 || almost_empty !== 1'b1 ||
        full !== 1'b0 || half !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got count=%0d data=%h empty=%b ae=%b unf=%b rv=%b",
                         count, data_out, empty, almost_empty, underflow, rd_valid);
    end
  endtask

  task automatic test_thresholds();
    int c;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int step = 0; step <= 2 * DEPTH; step++) begin
      if (step > 0) begin
        if (step <= DEPTH) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        else               drive(1'b0, 8'h00, 1'b1, 1'b0);
      end
      c = (step <= DEPTH) ? step : 2 * DEPTH - step;
      n_checks++;
      if (count !== 5'(c) || almost_empty !== (c <= 4) || almost_full !== (c >= 12) ||
          half !== (c == 8) || full !== (c == 16) || empty !== (c == 0)) begin
        n_fail++; $display("FAIL thresh_%0d got count=%0d ae=%b af=%b half=%b full=%b empty=%b",
                           c, count, almost_empty, almost_full, half, full, empty);
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    int          sz;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 2));
      sz  = m_q.size();
      got = {count, full, empty, half, almost_full, almost_empty, overflow, underflow, rd_valid, data_out};
      exp = {5'(sz), sz == DEPTH, sz == 0, sz == DEPTH / 2, sz >= DEPTH - 4, sz <= 4,
             m_ovf, m_unf, m_rv, m_dout};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_clear_rst();
    test_thresholds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
